// File: rtl/seg7_bcd_capture.sv
// ============================================================================
// Module   : seg7_bcd_capture
// Brief    : Captures a multiplexed 7-segment display into BCD digits/frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_bcd_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digit_bcd,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic [15:0] frame_bcd,
    output logic        frame_valid,
    output logic        frame_done
);

    localparam logic [7:0] c_CNT_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_CNT_CAP = 8'(STABLE_CYCLES - 1);

    logic [10:0] r_samp;
    logic [7:0]  r_cnt;
    logic        r_primed;
    logic [3:0]  r_seen;

    logic [10:0] w_in;
    logic        w_same;
    logic [3:0]  w_an_low;
    logic        w_one_low;
    logic        w_capture;
    logic [3:0]  w_dec_bcd;
    logic        w_dec_valid;
    logic        w_dec_err;
    logic [15:0] w_bcd_nx;
    logic [3:0]  w_valid_nx;
    logic [3:0]  w_err_nx;
    logic [3:0]  w_seen_nx;
    logic        w_frame;

    assign w_in      = {an, seg};
    // The first sample after reset never matches, so it cannot shorten the count.
    assign w_same    = r_primed && (w_in == r_samp);
    assign w_an_low  = ~r_samp[10:7];
    assign w_one_low = (w_an_low != 4'b0000) && ((w_an_low & (w_an_low - 4'b0001)) == 4'b0000);
    assign w_capture = w_same && (r_cnt == c_CNT_CAP) && w_one_low;

    always_comb begin
        w_dec_bcd   = 4'hE;
        w_dec_valid = 1'b1;
        w_dec_err   = 1'b0;
        case (r_samp[6:0])
            7'b0000001: w_dec_bcd = 4'd0;
            7'b1001111: w_dec_bcd = 4'd1;
            7'b0010010: w_dec_bcd = 4'd2;
            7'b0000110: w_dec_bcd = 4'd3;
            7'b1001100: w_dec_bcd = 4'd4;
            7'b0100100: w_dec_bcd = 4'd5;
            7'b0100000: w_dec_bcd = 4'd6;
            7'b0001111: w_dec_bcd = 4'd7;
            7'b0000000: w_dec_bcd = 4'd8;
            7'b0000100: w_dec_bcd = 4'd9;
            7'b1111111: begin
                w_dec_bcd   = 4'hF;
                w_dec_valid = 1'b0;
            end
            default: begin
                w_dec_bcd   = 4'hE;
                w_dec_valid = 1'b0;
                w_dec_err   = 1'b1;
            end
        endcase
    end

    // Merged view of the digit registers including the digit being captured now.
    always_comb begin
        w_bcd_nx   = digit_bcd;
        w_valid_nx = digit_valid;
        w_err_nx   = digit_err;
        for (int k = 0; k < 4; k++) begin
            if (w_an_low[k]) begin
                w_bcd_nx[4*k +: 4] = w_dec_bcd;
                w_valid_nx[k]      = w_dec_valid;
                w_err_nx[k]        = w_dec_err;
            end
        end
    end

    assign w_seen_nx = r_seen | w_an_low;
    assign w_frame   = &w_seen_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp   <= '0;
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else begin
            r_samp   <= w_in;
            r_primed <= 1'b1;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_bcd   <= 16'hFFFF;
            digit_valid <= '0;
            digit_err   <= '0;
            frame_bcd   <= 16'hFFFF;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            r_seen      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (w_capture) begin
                digit_bcd   <= w_bcd_nx;
                digit_valid <= w_valid_nx;
                digit_err   <= w_err_nx;
                if (w_frame) begin
                    frame_bcd   <= w_bcd_nx;
                    frame_valid <= &w_valid_nx;
                    frame_done  <= 1'b1;
                    r_seen      <= '0;
                end else begin
                    r_seen <= w_seen_nx;
                end
            end
        end
    end

endmodule

`default_nettype wire
